// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tag-tracking forwarding unit for the ID stage.
// Keeps the last FWD_DEPTH issued instructions in a shift pipeline of slots,
// each with a result-ready countdown, and derives per-source forward selects
// plus a load-use/latency stall for the instruction sitting in ID.
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), async active-low reset
//   rs1_in/rs2_in           ID source register indices
//   rs1_used_in/rs2_used_in ID instruction actually reads the source
//   issue_valid_in          ID holds a valid instruction requesting issue
//   issue_rd_in/_write_in   destination of the issuing instruction
//   issue_lat_in            slot index where its result first appears
//   flush_in                squash ID and slot 0 (redirect)
//   stall_out               hold PC and IF/ID, insert bubble
//   issue_fire_out          instruction leaves ID this cycle
//   fwd1_sel_out/fwd2_sel_out  operand source (0 = regfile, k+1 = slot k)
//
// Optional feature: define FWD_SCOREBOARD_PERF_EN to add the 32-bit
// perf_stall_cnt_out and perf_fwd_cnt_out counters.
module fwd_scoreboard #(
  parameter int unsigned FWD_DEPTH  = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned LAT_W      = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic                  rs1_used_in,
  input  logic                  rs2_used_in,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_in,
  input  logic                  issue_rd_write_in,
  input  logic [LAT_W-1:0]      issue_lat_in,
  input  logic                  flush_in,
`ifdef FWD_SCOREBOARD_PERF_EN
  output logic [31:0]           perf_stall_cnt_out,
  output logic [31:0]           perf_fwd_cnt_out,
`endif
  output logic                  stall_out,
  output logic                  issue_fire_out,
  output logic [SEL_W-1:0]      fwd1_sel_out,
  output logic [SEL_W-1:0]      fwd2_sel_out
);

  // Slot state: slot k holds the instruction issued k+1 cycles ago.
  logic [FWD_DEPTH-1:0]                 vld_q, vld_d;
  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [FWD_DEPTH-1:0][LAT_W-1:0]      cnt_q, cnt_d;

  logic [SEL_W:0]   src1_c, src2_c;
  logic [LAT_W-1:0] lat_clamped;

  // Youngest matching valid slot wins; {hazard, sel} result.
  function automatic logic [SEL_W:0] src_lookup(
    input logic [REG_ADDR_W-1:0]                 rs,
    input logic                                  used,
    input logic [FWD_DEPTH-1:0]                  vld,
    input logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0]  rd,
    input logic [FWD_DEPTH-1:0][LAT_W-1:0]       cnt
  );
    logic             hit;
    logic             haz;
    logic [SEL_W-1:0] sel;
    hit = 1'b0;
    haz = 1'b0;
    sel = '0;
    if (used && (rs != '0)) begin
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        if (!hit && vld[k] && (rd[k] == rs)) begin
          hit = 1'b1;
          if (cnt[k] != '0) begin
            haz = 1'b1;
          end else begin
            sel = SEL_W'(k + 1);
          end
        end
      end
    end
    return {haz, sel};
  endfunction

  // Source lookup, stall and issue decision.
  always_comb begin
    src1_c         = src_lookup(rs1_in, rs1_used_in, vld_q, rd_q, cnt_q);
    src2_c         = src_lookup(rs2_in, rs2_used_in, vld_q, rd_q, cnt_q);
    fwd1_sel_out   = src1_c[SEL_W-1:0];
    fwd2_sel_out   = src2_c[SEL_W-1:0];
    stall_out      = issue_valid_in & (src1_c[SEL_W] | src2_c[SEL_W]) & ~flush_in;
    issue_fire_out = issue_valid_in & ~stall_out & ~flush_in;
  end

  // Latencies beyond the last slot are pinned to the last slot.
  always_comb begin
    lat_clamped = issue_lat_in;
    if (32'(issue_lat_in) >= FWD_DEPTH) begin
      lat_clamped = LAT_W'(FWD_DEPTH - 1);
    end
  end

  // Shift all slots, count down, load slot 0 with the issue or a bubble.
  always_comb begin
    vld_d    = '0;
    rd_d     = '0;
    cnt_d    = '0;
    vld_d[0] = issue_fire_out & issue_rd_write_in & (issue_rd_in != '0);
    rd_d[0]  = issue_rd_in;
    cnt_d[0] = lat_clamped;
    for (int k = 1; k < int'(FWD_DEPTH); k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      cnt_d[k] = (cnt_q[k-1] != '0) ? (cnt_q[k-1] - LAT_W'(1)) : '0;
    end
    // A flush drops the wrong-path instruction currently in EX.
    vld_d[1] = vld_q[0] & ~flush_in;
  end

  // Slot state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Wrap-around event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall_out);
    fwd_cnt_d   = fwd_cnt_q
                + 32'(issue_fire_out & ((fwd1_sel_out != '0) | (fwd2_sel_out != '0)));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt_out = stall_cnt_q;
  assign perf_fwd_cnt_out   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard (FWD_DEPTH=3): directed vector table,
// reset-mid-stall sequence, then random traffic against an age-based model.
module tb_fwd_scoreboard;

  localparam int D  = 3;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1, rs2, rd;
  logic          u1, u2, iv, wr, fl;
  logic [LW-1:0] lat;
  logic          stall, fire;
  logic [SW-1:0] s1, s2;
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0]   perf_stall, perf_fwd;
`endif

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .FWD_DEPTH (D),
    .REG_ADDR_W(AW),
    .SEL_W     (SW),
    .LAT_W     (LW)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .rs1_in           (rs1),
    .rs2_in           (rs2),
    .rs1_used_in      (u1),
    .rs2_used_in      (u2),
    .issue_valid_in   (iv),
    .issue_rd_in      (rd),
    .issue_rd_write_in(wr),
    .issue_lat_in     (lat),
    .flush_in         (fl),
`ifdef FWD_SCOREBOARD_PERF_EN
    .perf_stall_cnt_out(perf_stall),
    .perf_fwd_cnt_out (perf_fwd),
`endif
    .stall_out        (stall),
    .issue_fire_out   (fire),
    .fwd1_sel_out     (s1),
    .fwd2_sel_out     (s2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: entry at age a was issued a cycles ago; its result is
  // available once a-1 >= its (clamped) latency.
  bit m_vld [D+1];
  int m_rd  [D+1];
  int m_lat [D+1];
  int m_stall_cnt = 0;
  int m_fwd_cnt   = 0;

  function automatic void m_clear();
    for (int a = 0; a <= D; a++) begin
      m_vld[a] = 1'b0;
      m_rd[a]  = 0;
      m_lat[a] = 0;
    end
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endfunction

  function automatic void m_lookup(input int rs, input bit used,
                                   output bit haz, output int sel);
    haz = 1'b0;
    sel = 0;
    if (!used || rs == 0) return;
    for (int a = 1; a <= D; a++) begin
      if (m_vld[a] && m_rd[a] == rs) begin
        if (a - 1 < m_lat[a]) haz = 1'b1;
        else sel = a;
        return;
      end
    end
  endfunction

  function automatic void m_outputs(output bit e_st, output bit e_fi,
                                    output int e_s1, output int e_s2);
    bit h1, h2;
    m_lookup(int'(rs1), u1, h1, e_s1);
    m_lookup(int'(rs2), u2, h2, e_s2);
    e_st = iv && (h1 || h2) && !fl;
    e_fi = iv && !e_st && !fl;
  endfunction

  function automatic void m_tick();
    bit e_st, e_fi;
    int e_s1, e_s2;
    if (!rst_n) begin
      m_clear();
      return;
    end
    m_outputs(e_st, e_fi, e_s1, e_s2);
    if (e_st) m_stall_cnt++;
    if (e_fi && (e_s1 != 0 || e_s2 != 0)) m_fwd_cnt++;
    for (int a = D; a >= 2; a--) begin
      m_vld[a] = m_vld[a-1];
      m_rd[a]  = m_rd[a-1];
      m_lat[a] = m_lat[a-1];
    end
    if (fl) m_vld[2] = 1'b0;
    m_vld[1] = e_fi && wr && (rd != '0);
    m_rd[1]  = int'(rd);
    m_lat[1] = (int'(lat) >= D) ? D - 1 : int'(lat);
  endfunction

  typedef struct {
    bit iv; int rd; bit wr; int lat;
    int rs1; bit u1; int rs2; bit u2; bit fl;
    bit e_stall; bit e_fire; int e_s1; int e_s2;
  } vec_t;

  function automatic vec_t mk(bit a_iv, int a_rd, bit a_wr, int a_lat,
                              int a_rs1, bit a_u1, int a_rs2, bit a_u2, bit a_fl,
                              bit e_st, bit e_fi, int e1, int e2);
    vec_t r;
    r.iv = a_iv; r.rd = a_rd; r.wr = a_wr; r.lat = a_lat;
    r.rs1 = a_rs1; r.u1 = a_u1; r.rs2 = a_rs2; r.u2 = a_u2; r.fl = a_fl;
    r.e_stall = e_st; r.e_fire = e_fi; r.e_s1 = e1; r.e_s2 = e2;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    iv  = r.iv;  rd  = AW'(r.rd);  wr = r.wr; lat = LW'(r.lat);
    rs1 = AW'(r.rs1); u1 = r.u1; rs2 = AW'(r.rs2); u2 = r.u2; fl = r.fl;
  endtask

  task automatic check_outs(input string tag, input bit e_st, input bit e_fi,
                            input int e1, input int e2);
    check({tag, ".stall"}, int'(stall), int'(e_st));
    check({tag, ".fire"},  int'(fire),  int'(e_fi));
    check({tag, ".sel1"},  int'(s1),    e1);
    check({tag, ".sel2"},  int'(s2),    e2);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  vec_t vecs[30];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e_st, e_fi;
    int e1, e2;
    vec_t r;

    // iv rd wr lat | rs1 u1 rs2 u2 fl | stall fire sel1 sel2
    vecs[0]  = mk(1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0); // ALU x5
    vecs[1]  = mk(1, 1, 0, 0,  5, 1, 0, 0, 0,  0, 1, 1, 0);
    vecs[2]  = mk(1, 1, 0, 0,  5, 1, 0, 0, 0,  0, 1, 2, 0);
    vecs[3]  = mk(1, 1, 0, 0,  5, 1, 0, 0, 0,  0, 1, 3, 0);
    vecs[4]  = mk(1, 1, 0, 0,  5, 1, 0, 0, 0,  0, 1, 0, 0);
    vecs[5]  = mk(1, 6, 1, 1,  0, 0, 0, 0, 0,  0, 1, 0, 0); // load x6
    vecs[6]  = mk(1, 2, 1, 0,  0, 0, 6, 1, 0,  1, 0, 0, 0);
    vecs[7]  = mk(1, 2, 1, 0,  0, 0, 6, 1, 0,  0, 1, 0, 2);
    vecs[8]  = mk(1, 8, 1, 2,  0, 0, 0, 0, 0,  0, 1, 0, 0); // mul x8
    vecs[9]  = mk(1, 3, 1, 0,  8, 1, 0, 0, 0,  1, 0, 0, 0);
    vecs[10] = mk(1, 3, 1, 0,  8, 1, 0, 0, 0,  1, 0, 0, 0);
    vecs[11] = mk(1, 3, 1, 0,  8, 1, 0, 0, 0,  0, 1, 3, 0);
    vecs[12] = mk(1, 8, 1, 2,  0, 0, 0, 0, 0,  0, 1, 0, 0); // mul x8, unused read
    vecs[13] = mk(1, 4, 0, 0,  8, 0, 0, 0, 0,  0, 1, 0, 0);
    vecs[14] = mk(1, 7, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0); // double writer x7
    vecs[15] = mk(1, 7, 1, 0,  7, 1, 0, 0, 0,  0, 1, 1, 0);
    vecs[16] = mk(1, 0, 0, 0,  7, 1, 7, 1, 0,  0, 1, 1, 1);
    vecs[17] = mk(1, 0, 1, 2,  0, 0, 0, 0, 0,  0, 1, 0, 0); // write x0, lat 2
    vecs[18] = mk(1, 0, 0, 0,  0, 1, 0, 1, 0,  0, 1, 0, 0);
    vecs[19] = mk(1, 9, 1, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0); // x9 then flush
    vecs[20] = mk(1,10, 1, 0,  9, 1, 0, 0, 1,  0, 0, 1, 0);
    vecs[21] = mk(1,11, 0, 0,  9, 1,10, 1, 0,  0, 1, 0, 0);
    vecs[22] = mk(1,11, 0, 0,  9, 1,10, 1, 0,  0, 1, 0, 0);
    vecs[23] = mk(1,12, 1, 1,  0, 0, 0, 0, 0,  0, 1, 0, 0); // flush over a stall
    vecs[24] = mk(1,14, 1, 0, 12, 1, 0, 0, 1,  0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 12, 1, 0, 0, 0,  0, 0, 0, 0);
    vecs[26] = mk(1,13, 1, 3,  0, 0, 0, 0, 0,  0, 1, 0, 0); // lat 3 clamps to 2
    vecs[27] = mk(1, 1, 0, 0, 13, 1, 0, 0, 0,  1, 0, 0, 0);
    vecs[28] = mk(1, 1, 0, 0, 13, 1, 0, 0, 0,  1, 0, 0, 0);
    vecs[29] = mk(1, 1, 0, 0, 13, 1, 0, 0, 0,  0, 1, 3, 0);

    // Reset state.
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    iv = 1'b1; rs1 = AW'(3); u1 = 1'b1;
    #1;
    check_outs("reset", 1'b0, 1'b1, 0, 0);
    iv = 1'b0; u1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 30; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fire,
                 vecs[i].e_s1, vecs[i].e_s2);
      finish_cycle();
    end

    // Reset while a dependent is stalled on a latency-2 load.
    drive(mk(1, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_outs("rst_ld", 1'b0, 1'b1, 0, 0);
    finish_cycle();
    drive(mk(1, 3, 1, 0, 6, 1, 6, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_outs("rst_pre", 1'b1, 1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    check_outs("rst_mid", 1'b0, 1'b1, 0, 0);
    @(posedge clk);
    m_tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("rst_post%0d", i), 1'b0, 1'b1, 0, 0);
      finish_cycle();
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = mk($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
             $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
             0, 0, 0, 0);
      drive(r);
      @(negedge clk);
      m_outputs(e_st, e_fi, e1, e2);
      check_outs($sformatf("rnd%0d", i), e_st, e_fi, e1, e2);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        m_outputs(e_st, e_fi, e1, e2);
        check_outs($sformatf("rnd_rst%0d", i), e_st, e_fi, e1, e2);
        @(posedge clk);
        m_tick();
        #2;
        rst_n = 1'b1;
      end else begin
        finish_cycle();
      end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    check("perf_stall", int'(perf_stall), m_stall_cnt);
    check("perf_fwd",   int'(perf_fwd),   m_fwd_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
